// File: rtl/qlink_pkg.sv
// Shared types and constants for the inter-board question link.
// Provides the FSM state encoding and the check-nibble helper.
package qlink_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    SETUP,
    STROBE,
    GAP
  } state_t;

  localparam int NIBBLES = 6;
  localparam int NIB_W   = 4;
  localparam int Q_W     = 24;
  localparam int RES_W   = 2;

  function automatic logic [NIB_W-1:0] xor_nibbles(input logic [Q_W-1:0] q);
    logic [NIB_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      acc = acc ^ q[i*NIB_W +: NIB_W];
    end
    return acc;
  endfunction

endpackage

// File: rtl/qlink_sync2.sv
// Two-flop synchroniser for asynchronous GPIO inputs; width is a parameter.
module qlink_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= '0;
      q       <= '0;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/question_link_tx.sv
// Sending end of the question link: latches a 24-bit question and strobes it out
// nibble by nibble once the peer is ready. QLINK_PARITY_EN appends an XOR check nibble.
module question_link_tx
  import qlink_pkg::*;
#(
  parameter int STROBE_CYC  = 50000,
  parameter int GAP_CYC     = 50000,
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SEND,
  input  logic [Q_W-1:0]   QUESTION_IN,
  input  logic             PEER_READY_IN,
  input  logic [RES_W-1:0] RESULT_IN,
  output logic [NIB_W-1:0] NUM_OUT,
  output logic             OK_OUT,
  output logic [RES_W-1:0] JUDG_OUT,
  output logic             BUSY,
  output logic             DONE,
  output logic             TIMEOUT
);

  localparam int MAX_SG  = (STROBE_CYC > GAP_CYC) ? STROBE_CYC : GAP_CYC;
  localparam int MAX_CYC = (TIMEOUT_CYC > MAX_SG) ? TIMEOUT_CYC : MAX_SG;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

`ifdef QLINK_PARITY_EN
  localparam int FRAME_NIB = NIBBLES + 1;
`else
  localparam int FRAME_NIB = NIBBLES;
`endif
  localparam int SHIFT_W = FRAME_NIB * NIB_W;
  localparam int NIB_CW  = $clog2(FRAME_NIB + 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [NIB_CW-1:0]  nib, nib_n;
  logic [SHIFT_W-1:0] shift, shift_n, load;
  logic [NIB_W-1:0]   num_n;
  logic               ok_n, busy_n, done_n, timeout_n;
  logic [0:0]         ready_s;
  logic [RES_W-1:0]   result_s;

  qlink_sync2 #(.W(1)) u_ready_sync (
    .clk   (CLK),
    .rst_n (RST),
    .d     (PEER_READY_IN),
    .q     (ready_s)
  );

  qlink_sync2 #(.W(RES_W)) u_result_sync (
    .clk   (CLK),
    .rst_n (RST),
    .d     (RESULT_IN),
    .q     (result_s)
  );

  // Result relay: third register stage after the synchroniser
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) JUDG_OUT <= '0;
    else      JUDG_OUT <= result_s;
  end

`ifdef QLINK_PARITY_EN
  assign load = {QUESTION_IN, xor_nibbles(QUESTION_IN)};
`else
  assign load = QUESTION_IN;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      cnt     <= '0;
      nib     <= '0;
      shift   <= '0;
      NUM_OUT <= '0;
      OK_OUT  <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      TIMEOUT <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      nib     <= nib_n;
      shift   <= shift_n;
      NUM_OUT <= num_n;
      OK_OUT  <= ok_n;
      BUSY    <= busy_n;
      DONE    <= done_n;
      TIMEOUT <= timeout_n;
    end
  end

  // Outputs are registered: each branch sets the value seen in the next state
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    nib_n     = nib;
    shift_n   = shift;
    num_n     = NUM_OUT;
    ok_n      = OK_OUT;
    busy_n    = BUSY;
    done_n    = 1'b0;
    timeout_n = TIMEOUT;
    case (state)
      IDLE: begin
        if (SEND) begin
          shift_n   = load;
          timeout_n = 1'b0;
          busy_n    = 1'b1;
          cnt_n     = '0;
          nib_n     = '0;
          state_n   = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (ready_s[0]) begin
          num_n   = shift[SHIFT_W-1 -: NIB_W];
          cnt_n   = '0;
          state_n = SETUP;
        end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          timeout_n = 1'b1;
          busy_n    = 1'b0;
          num_n     = '0;
          cnt_n     = '0;
          state_n   = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      SETUP: begin
        ok_n    = 1'b1;
        cnt_n   = '0;
        state_n = STROBE;
      end
      STROBE: begin
        if (cnt == CNT_W'(STROBE_CYC - 1)) begin
          ok_n    = 1'b0;
          cnt_n   = '0;
          state_n = GAP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == CNT_W'(GAP_CYC - 1)) begin
          shift_n = {shift[SHIFT_W-NIB_W-1:0], {NIB_W{1'b0}}};
          nib_n   = nib + NIB_CW'(1);
          cnt_n   = '0;
          if (nib_n == NIB_CW'(FRAME_NIB)) begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            num_n   = '0;
            state_n = IDLE;
          end else begin
            num_n   = shift[SHIFT_W-NIB_W-1 -: NIB_W];
            state_n = SETUP;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_question_link_tx.sv
// Scoreboard bench for question_link_tx: stimulus pushes expected nibbles and DONE
// cycles, a negedge monitor pops and compares. Honours QLINK_PARITY_EN.
module tb_question_link_tx;

  localparam int STROBE_CYC  = 4;
  localparam int GAP_CYC     = 3;
  localparam int TIMEOUT_CYC = 20;
`ifdef QLINK_PARITY_EN
  localparam int FRAME_NIB = 7;
`else
  localparam int FRAME_NIB = 6;
`endif
  localparam int FIRST_OK = 3;
  localparam int DONE_LAT = 2 + FRAME_NIB * (1 + STROBE_CYC + GAP_CYC);

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        SEND = 1'b0;
  logic [23:0] QUESTION_IN = '0;
  logic        PEER_READY_IN = 1'b0;
  logic [1:0]  RESULT_IN = '0;
  logic [3:0]  NUM_OUT;
  logic        OK_OUT;
  logic [1:0]  JUDG_OUT;
  logic        BUSY, DONE, TIMEOUT;

  question_link_tx #(
    .STROBE_CYC  (STROBE_CYC),
    .GAP_CYC     (GAP_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .SEND          (SEND),
    .QUESTION_IN   (QUESTION_IN),
    .PEER_READY_IN (PEER_READY_IN),
    .RESULT_IN     (RESULT_IN),
    .NUM_OUT       (NUM_OUT),
    .OK_OUT        (OK_OUT),
    .JUDG_OUT      (JUDG_OUT),
    .BUSY          (BUSY),
    .DONE          (DONE),
    .TIMEOUT       (TIMEOUT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int exp_nib[$];
  int done_q[$];
  int done_seen = 0;
  int rise_seen = 0;
  int last_rise_cyc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: nibbles MSB first, optional XOR check nibble
  task automatic push_frame(input logic [23:0] q, input int t0);
    int p;
    p = 0;
    for (int i = 0; i < 6; i++) begin
      exp_nib.push_back(int'((q >> (4 * (5 - i))) & 24'hF));
      p = p ^ int'((q >> (4 * i)) & 24'hF);
    end
    if (FRAME_NIB == 7) exp_nib.push_back(p);
    done_q.push_back(t0 + DONE_LAT);
  endtask

  task automatic send(input logic [23:0] q, input bit expect_frame, output int t0);
    @(negedge CLK);
    SEND = 1'b1;
    QUESTION_IN = q;
    t0 = cyc;
    if (expect_frame) push_frame(q, t0);
    @(negedge CLK);
    SEND = 1'b0;
    QUESTION_IN = 24'($urandom);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  task automatic wait_done(input string name);
    int start;
    start = done_seen;
    for (int i = 0; i < DONE_LAT + 20 && done_seen == start; i++) @(negedge CLK);
    check(name, done_seen - start, 1);
    @(negedge CLK);
    check({name, "_busy_low"}, BUSY, 0);
    check({name, "_num_zero"}, NUM_OUT, 0);
  endtask

  task automatic judg_step(input logic [1:0] v);
    logic [1:0] old;
    int t;
    @(negedge CLK);
    old = RESULT_IN;
    RESULT_IN = v;
    t = cyc;
    wait_until(t + 2);
    check("judg_not_early", JUDG_OUT, old);
    wait_until(t + 3);
    check("judg_latency3", JUDG_OUT, v);
  endtask

  // Monitor: pops expected nibbles on each OK rise and expected DONE cycles on each DONE
  initial begin
    bit prev_ok;
    int hi_cnt;
    int cur_nib;
    prev_ok = 0;
    hi_cnt = 0;
    cur_nib = -1;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        prev_ok = 0;
        hi_cnt = 0;
      end else begin
        if (OK_OUT && !prev_ok) begin
          rise_seen++;
          last_rise_cyc = cyc;
          hi_cnt = 0;
          check("nibble_expected", exp_nib.size() != 0, 1);
          cur_nib = (exp_nib.size() != 0) ? exp_nib.pop_front() : -1;
        end
        if (OK_OUT) begin
          hi_cnt++;
          check("nibble_value", 32'(NUM_OUT), 32'(cur_nib));
        end
        if (!OK_OUT && prev_ok) check("strobe_len", hi_cnt, STROBE_CYC);
        if (DONE) begin
          done_seen++;
          check("done_expected", done_q.size() != 0, 1);
          if (done_q.size() != 0) check("done_cycle", cyc, done_q.pop_front());
          check("done_all_nibbles", exp_nib.size(), 0);
        end
        prev_ok = OK_OUT;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, r0, d0;
    logic [23:0] q;

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_num", NUM_OUT, 0);
    check("rst_ok", OK_OUT, 0);
    check("rst_judg", JUDG_OUT, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_timeout", TIMEOUT, 0);
    RST = 1'b1;
    PEER_READY_IN = 1'b1;
    repeat (4) @(negedge CLK);

    // Directed frame with first-strobe timing
    r0 = rise_seen;
    send(24'h123456, 1, t0);
    check("busy_after_send", BUSY, 1);
    for (int i = 0; i < 10 && rise_seen == r0; i++) @(negedge CLK);
    check("first_ok_cycle", last_rise_cyc - t0, FIRST_OK);
    wait_done("frame_123456");

    // Random frames with result relay exercised mid-frame
    for (int k = 0; k < 4; k++) begin
      q = 24'($urandom);
      send(q, 1, t0);
      judg_step(2'($urandom));
      wait_done("frame_random");
    end

    // Timeout with peer not ready, then recovery
    PEER_READY_IN = 1'b0;
    repeat (4) @(negedge CLK);
    send(24'hABCDEF, 0, t0);
    for (int i = 0; i < 3 * TIMEOUT_CYC && !TIMEOUT; i++) @(negedge CLK);
    check("timeout_cycle", cyc - t0, TIMEOUT_CYC + 1);
    check("timeout_flag", TIMEOUT, 1);
    check("timeout_busy", BUSY, 0);
    check("timeout_num", NUM_OUT, 0);
    repeat (3) @(negedge CLK);
    check("timeout_sticky", TIMEOUT, 1);
    PEER_READY_IN = 1'b1;
    repeat (4) @(negedge CLK);
    send(24'h0F0F0F, 1, t0);
    check("timeout_cleared", TIMEOUT, 0);
    wait_done("frame_after_timeout");

    // SEND during frame ignored, ready drop mid-frame ignored
    d0 = done_seen;
    send(24'h987654, 1, t0);
    wait_until(t0 + 2 + 2 * (1 + STROBE_CYC + GAP_CYC) + 2);
    send(24'h111111, 0, t1);
    wait_until(t0 + 2 + 3 * (1 + STROBE_CYC + GAP_CYC) + 1);
    PEER_READY_IN = 1'b0;
    wait_done("frame_ready_drop");
    repeat (2 * DONE_LAT) @(negedge CLK);
    check("single_done", done_seen - d0, 1);
    PEER_READY_IN = 1'b1;
    repeat (4) @(negedge CLK);

    // Reset during strobe of nibble 2
    d0 = done_seen;
    send(24'h55AA33, 1, t0);
    wait_until(t0 + 2 + (1 + STROBE_CYC + GAP_CYC) + 2);
    check("pre_reset_ok", OK_OUT, 1);
    #2;
    RST = 1'b0;
    exp_nib.delete();
    done_q.delete();
    #1;
    check("reset_num", NUM_OUT, 0);
    check("reset_ok", OK_OUT, 0);
    check("reset_busy", BUSY, 0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (DONE_LAT) @(negedge CLK);
    check("reset_no_done", done_seen - d0, 0);
    send(24'h123456, 1, t0);
    wait_done("frame_after_reset");

    // Result relay while idle
    judg_step(2'b00);
    judg_step(2'b10);
    judg_step(2'b01);

    check("scoreboard_nib_empty", exp_nib.size(), 0);
    check("scoreboard_done_empty", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
